// File: rtl/board_pkg.sv
// Board geometry shared by the renderer and the pixel-to-cell mapper.
// Boundaries sit midway between the renderer's cell centres.
package board_pkg;

    typedef logic [3:0] board_pos_t;

    localparam board_pos_t POS_NONE    = 4'hF;
    localparam board_pos_t BOARD_CELLS = 4'd9;

    // Cell centres are x 200/425/650 and y 75/230/400.
    localparam logic [9:0] GRID_X_MIN = 10'd100;
    localparam logic [9:0] GRID_X_B1  = 10'd312;
    localparam logic [9:0] GRID_X_B2  = 10'd537;
    localparam logic [9:0] GRID_X_MAX = 10'd760;
    localparam logic [9:0] GRID_Y_B1  = 10'd152;
    localparam logic [9:0] GRID_Y_B2  = 10'd315;
    localparam logic [9:0] GRID_Y_MAX = 10'd480;

    function automatic board_pos_t cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

    function automatic logic pos_selectable(input board_pos_t p);
        return p < BOARD_CELLS;
    endfunction

endpackage

// File: rtl/axis_bin.sv
// Single-axis binning: maps a coordinate to bin 0..2 and that bin's origin.
// Coordinates below ORG0 still land in bin 0; the caller qualifies the range.
module axis_bin #(
    parameter logic [9:0] ORG0 = 10'd0,
    parameter logic [9:0] B1   = 10'd1,
    parameter logic [9:0] B2   = 10'd2
) (
    input  logic [9:0] coord,
    output logic [1:0] idx,
    output logic [9:0] origin
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch inferred.
        idx    = 2'd2;
        origin = B2;
        if (coord < B1) begin
            idx    = 2'd0;
            origin = ORG0;
        end else if (coord < B2) begin
            idx    = 2'd1;
            origin = B1;
        end
    end

endmodule

// File: rtl/pixel_to_pos.sv
// Maps the visible VGA scan coordinate to a 3x3 board cell, the in-cell offset
// and a selected-cell flag. Two register stages, one pixel per clock.
module pixel_to_pos
    import board_pkg::*;
#(
    parameter logic [9:0] X_MIN = GRID_X_MIN,
    parameter logic [9:0] X_B1  = GRID_X_B1,
    parameter logic [9:0] X_B2  = GRID_X_B2,
    parameter logic [9:0] X_MAX = GRID_X_MAX,
    parameter logic [9:0] Y_B1  = GRID_Y_B1,
    parameter logic [9:0] Y_B2  = GRID_Y_B2,
    parameter logic [9:0] Y_MAX = GRID_Y_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [9:0] pixx,
    input  logic [9:0] pixy,
    input  logic [3:0] sel_pos,
    output logic       out_valid,
    output logic [3:0] pos,
    output logic       in_grid,
    output logic [9:0] dx,
    output logic [9:0] dy,
    output logic       is_sel
);

    logic [1:0] x_idx, y_idx;
    logic [9:0] x_org, y_org;

    axis_bin #(.ORG0(X_MIN), .B1(X_B1), .B2(X_B2)) u_x_bin (
        .coord  (pixx),
        .idx    (x_idx),
        .origin (x_org)
    );

    axis_bin #(.ORG0(10'd0), .B1(Y_B1), .B2(Y_B2)) u_y_bin (
        .coord  (pixy),
        .idx    (y_idx),
        .origin (y_org)
    );

    // Stage 1: binning results plus the raw coordinate and cursor.
    logic       v1_d, v1_q;
    logic [1:0] col_d, col_q, row_d, row_q;
    logic       inside_d, inside_q;
    logic [9:0] pixx_d, pixx_q, pixy_d, pixy_q;
    logic [9:0] xorg_d, xorg_q, yorg_d, yorg_q;
    board_pos_t sel_d, sel_q;

    always_comb begin
        v1_d     = in_valid;
        col_d    = col_q;
        row_d    = row_q;
        inside_d = inside_q;
        pixx_d   = pixx_q;
        pixy_d   = pixy_q;
        xorg_d   = xorg_q;
        yorg_d   = yorg_q;
        sel_d    = sel_q;
        if (in_valid) begin
            col_d    = x_idx;
            row_d    = y_idx;
            inside_d = (pixx >= X_MIN) && (pixx < X_MAX) && (pixy < Y_MAX);
            pixx_d   = pixx;
            pixy_d   = pixy;
            xorg_d   = x_org;
            yorg_d   = y_org;
            sel_d    = sel_pos;
        end
    end

    // Stage 2: cell index and offsets; subtraction only when inside, so no wrap.
    logic       v2_d, v2_q;
    board_pos_t pos_d, pos_q;
    logic       in_grid_d, in_grid_q;
    logic [9:0] dx_d, dx_q, dy_d, dy_q;
    logic       is_sel_d, is_sel_q;

    always_comb begin
        v2_d      = v1_q;
        pos_d     = pos_q;
        in_grid_d = in_grid_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        is_sel_d  = is_sel_q;
        if (v1_q) begin
            in_grid_d = inside_q;
            if (inside_q) begin
                pos_d    = cell_index(row_q, col_q);
                dx_d     = pixx_q - xorg_q;
                dy_d     = pixy_q - yorg_q;
                is_sel_d = pos_selectable(sel_q) && (pos_d == sel_q);
            end else begin
                pos_d    = POS_NONE;
                dx_d     = 10'd0;
                dy_d     = 10'd0;
                is_sel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared too, so outputs show defined values out of reset.
            v1_q      <= 1'b0;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            inside_q  <= 1'b0;
            pixx_q    <= 10'd0;
            pixy_q    <= 10'd0;
            xorg_q    <= 10'd0;
            yorg_q    <= 10'd0;
            sel_q     <= POS_NONE;
            v2_q      <= 1'b0;
            pos_q     <= POS_NONE;
            in_grid_q <= 1'b0;
            dx_q      <= 10'd0;
            dy_q      <= 10'd0;
            is_sel_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so stage 2 sees stage 1's previous value, not this cycle's.
            v1_q      <= v1_d;
            col_q     <= col_d;
            row_q     <= row_d;
            inside_q  <= inside_d;
            pixx_q    <= pixx_d;
            pixy_q    <= pixy_d;
            xorg_q    <= xorg_d;
            yorg_q    <= yorg_d;
            sel_q     <= sel_d;
            v2_q      <= v2_d;
            pos_q     <= pos_d;
            in_grid_q <= in_grid_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            is_sel_q  <= is_sel_d;
        end
    end

    assign out_valid = v2_q;
    assign pos       = pos_q;
    assign in_grid   = in_grid_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign is_sel    = is_sel_q;

endmodule

// File: tb/tb_pixel_to_pos.sv
// Scoreboard bench for pixel_to_pos: the driver queues hand-computed results,
// a monitor on the falling edge pops and compares whenever out_valid is high.
module tb_pixel_to_pos;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] pixx, pixy;
    logic [3:0] sel_pos;
    logic       out_valid;
    logic [3:0] pos;
    logic       in_grid;
    logic [9:0] dx, dy;
    logic       is_sel;

    pixel_to_pos dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .pixx      (pixx),
        .pixy      (pixy),
        .sel_pos   (sel_pos),
        .out_valid (out_valid),
        .pos       (pos),
        .in_grid   (in_grid),
        .dx        (dx),
        .dy        (dy),
        .is_sel    (is_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pos;
        logic       in_grid;
        logic [9:0] dx;
        logic [9:0] dy;
        logic       is_sel;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cycle_cnt = 0;
    int   n_sent   = 0;
    int   n_seen   = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    // Monitor: every out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_seen++;
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", int'(out_valid), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("latency", cycle_cnt - e.cyc, 2);
                check("pos",     int'(pos),     int'(e.pos));
                check("in_grid", int'(in_grid), int'(e.in_grid));
                check("dx",      int'(dx),      int'(e.dx));
                check("dy",      int'(dy),      int'(e.dy));
                check("is_sel",  int'(is_sel),  int'(e.is_sel));
            end
        end
    end

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [3:0] sel,
                        input logic [3:0] epos, input logic eg, input logic [9:0] edx,
                        input logic [9:0] edy, input logic es);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        pixx     = x;
        pixy     = y;
        sel_pos  = sel;
        e.pos = epos; e.in_grid = eg; e.dx = edx; e.dy = edy; e.is_sel = es;
        e.cyc = cycle_cnt;
        sb_q.push_back(e);
        n_sent++;
    endtask

    task automatic send_out(input logic [9:0] x, input logic [9:0] y, input logic [3:0] sel);
        send(x, y, sel, 4'hF, 1'b0, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        pixx     = 10'($urandom_range(0, 1023));
        pixy     = 10'($urandom_range(0, 1023));
        sel_pos  = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; pixx = '0; pixy = '0; sel_pos = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pos",       int'(pos),       15);
        check("rst_in_grid",   int'(in_grid),   0);
        check("rst_dx",        int'(dx),        0);
        check("rst_dy",        int'(dy),        0);
        check("rst_is_sel",    int'(is_sel),    0);
        rst = 1'b0;

        // Cell centres and corners.
        send(10'd200, 10'd75,  4'd0, 4'd0, 1'b1, 10'd100, 10'd75, 1'b1);
        send(10'd650, 10'd400, 4'd4, 4'd8, 1'b1, 10'd113, 10'd85, 1'b0);
        idle();
        // Column and row boundaries.
        send(10'd311, 10'd100, 4'd0, 4'd0, 1'b1, 10'd211, 10'd100, 1'b1);
        send(10'd312, 10'd100, 4'd0, 4'd1, 1'b1, 10'd0,   10'd100, 1'b0);
        send(10'd400, 10'd314, 4'd4, 4'd4, 1'b1, 10'd88,  10'd162, 1'b1);
        send(10'd400, 10'd315, 4'd4, 4'd7, 1'b1, 10'd88,  10'd0,   1'b0);
        send(10'd759, 10'd479, 4'd8, 4'd8, 1'b1, 10'd222, 10'd164, 1'b1);
        send(10'd100, 10'd0,   4'd0, 4'd0, 1'b1, 10'd0,   10'd0,   1'b1);
        // Just outside each edge, and a selected cell that cannot match.
        send_out(10'd760, 10'd200, 4'd5);
        send_out(10'd99,  10'd0,   4'd0);
        send_out(10'd400, 10'd480, 4'd4);
        send_out(10'd50,  10'd230, 4'd3);
        idle();
        idle();
        // Back-to-back stream; cursor moves on the third pixel.
        send(10'd425, 10'd230, 4'd4, 4'd4, 1'b1, 10'd113, 10'd78, 1'b1);
        send(10'd426, 10'd230, 4'd4, 4'd4, 1'b1, 10'd114, 10'd78, 1'b1);
        send(10'd427, 10'd230, 4'd9, 4'd4, 1'b1, 10'd115, 10'd78, 1'b0);
        idle();
        repeat (4) idle();

        // Two pixels in flight when reset hits: neither may emerge.
        @(negedge clk);
        in_valid = 1'b1; pixx = 10'd200; pixy = 10'd75; sel_pos = 4'd0;
        @(negedge clk);
        in_valid = 1'b1; pixx = 10'd650; pixy = 10'd400; sel_pos = 4'd8;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", int'(out_valid), 0);
        idle();
        idle();
        send(10'd425, 10'd75, 4'd1, 4'd1, 1'b1, 10'd113, 10'd75, 1'b1);
        idle();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_pending", sb_q.size(), 0);
        check("outputs_seen", n_seen, n_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
